ext_io_device: RTL

EXT_IO_DEVICE -- requirements
Module: ext_io_device

---
 rtl/ext_io_pkg.sv | 28 ++
 rtl/ext_io_refill_gen.sv | 54 +++++
 rtl/ext_io_device.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ext_io_pkg.sv
// ext_io_pkg: shared types, LFSR constants and refill pattern helpers for
// the ext_io_device slice.
package ext_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    REFILL
  } state_t;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  // Pattern word for word j of beat i: {batch, i[3:0], j[3:0]}
  function automatic logic [15:0] pattern_word(input logic [7:0] batch,
                                               input logic [3:0] beat,
                                               input logic [3:0] word);
    return {batch, beat, word};
  endfunction

  // One Galois LFSR step
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/ext_io_refill_gen.sv
// ext_io_refill_gen: produces the beat written during one refill cycle.
// Build macro EXT_DEV_LFSR_EN selects a 32-bit Galois LFSR source that
// advances once per word; otherwise the beat is the batch/index pattern.
module ext_io_refill_gen
  import ext_io_pkg::*;
#(
  parameter int WORD_W     = 16,
  parameter int BEAT_WORDS = 4,
  parameter int OFF_W      = 2
) (
`ifdef EXT_DEV_LFSR_EN
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         step,
`else
  input  logic [7:0]                   batch,
  input  logic [OFF_W-1:0]             index,
`endif
  output logic [BEAT_WORDS*WORD_W-1:0] beat
);

`ifdef EXT_DEV_LFSR_EN
  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // Chain BEAT_WORDS LFSR steps, one per word in word order
  always_comb begin
    lfsr_d = lfsr_q;
    beat   = '0;
    for (int j = 0; j < BEAT_WORDS; j++) begin
      lfsr_d = lfsr_step(lfsr_d);
      beat[j*WORD_W +: WORD_W] = lfsr_d[WORD_W-1:0];
    end
  end

  // LFSR state: seeded on reset, advanced only when a beat is consumed
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (step) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  // Deterministic pattern beat from batch number and beat index
  always_comb begin
    beat = '0;
    for (int j = 0; j < BEAT_WORDS; j++) begin
      beat[j*WORD_W +: WORD_W] = WORD_W'(pattern_word(batch, 4'(index), 4'(j)));
    end
  end
`endif

endmodule

// File: rtl/ext_io_device.sv
// ext_io_device: batch-buffered I/O device. After an idle interval it raises
// an interrupt; once acknowledged it serves DEPTH beats by offset, then
// refills its storage and starts over. Build macro EXT_DEV_LFSR_EN switches
// the refill data source to an LFSR.
module ext_io_device
  import ext_io_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int BEAT_WORDS  = 4,
  parameter int DEPTH       = 3,
  parameter int OFF_W       = 2,
  parameter int FIRE_CYCLES = 520,
  parameter int INT_TIMEOUT = 130
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [OFF_W-1:0]             offset,
  input  logic                         rd_en,
  input  logic                         int_ack,
  output logic                         interrupt,
  output logic [BEAT_WORDS*WORD_W-1:0] data,
  output logic                         data_valid,
  output logic                         rd_err,
  output logic                         batch_done,
  output logic                         missed
);

  localparam int DATA_W = BEAT_WORDS * WORD_W;
  localparam int FIRE_W = $clog2(FIRE_CYCLES + 1);
  localparam int HOLD_W = $clog2(INT_TIMEOUT + 1);
  localparam int IDX_W  = $clog2(DEPTH + 1);

  state_t            state_q, state_d;
  logic [FIRE_W-1:0] fire_q, fire_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        batch_q, batch_d;
  logic [DEPTH-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0] storage [DEPTH];
  logic [DATA_W-1:0] fill_beat;
  logic [DATA_W-1:0] data_d;
  logic [OFF_W-1:0]  fill_off;
  logic              int_d, valid_d, err_d, done_d, missed_d;
  logic              wr_en, in_range;

  assign in_range = (32'(offset) < DEPTH);
  assign fill_off = OFF_W'(idx_q);

`ifdef EXT_DEV_LFSR_EN
  ext_io_refill_gen #(.WORD_W(WORD_W), .BEAT_WORDS(BEAT_WORDS), .OFF_W(OFF_W)) u_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .step   (wr_en),
    .beat   (fill_beat)
  );
`else
  ext_io_refill_gen #(.WORD_W(WORD_W), .BEAT_WORDS(BEAT_WORDS), .OFF_W(OFF_W)) u_gen (
    .batch(batch_q),
    .index(fill_off),
    .beat (fill_beat)
  );
`endif

  // Next-state and next-output logic; REFILL spends one extra cycle after
  // the last beat to bump the batch and clear the read mask
  always_comb begin
    state_d  = state_q;
    fire_d   = fire_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    batch_d  = batch_q;
    mask_d   = mask_q;
    int_d    = 1'b0;
    data_d   = '0;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    missed_d = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire_q == '0) begin
          state_d = REQ;
          hold_d  = '0;
          int_d   = 1'b1;
        end else begin
          fire_d = fire_q - 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = XFER;
        end else if (hold_q == HOLD_W'(INT_TIMEOUT - 1)) begin
          state_d  = IDLE;
          fire_d   = FIRE_W'(FIRE_CYCLES - 1);
          missed_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
          int_d  = 1'b1;
        end
      end
      XFER: begin
        if (rd_en && in_range) begin
          data_d         = storage[offset];
          valid_d        = 1'b1;
          mask_d[offset] = 1'b1;
          if (&mask_d) begin
            state_d = REFILL;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      REFILL: begin
        if (idx_q == IDX_W'(DEPTH)) begin
          batch_d = batch_q + 1'b1;
          mask_d  = '0;
          state_d = IDLE;
          fire_d  = FIRE_W'(FIRE_CYCLES - 1);
        end else begin
          wr_en = 1'b1;
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
    if (rd_en && !(state_q == XFER && in_range)) begin
      err_d = 1'b1;
    end
  end

  // State and registered outputs; reset forces a full refill from batch 0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= REFILL;
      fire_q     <= '0;
      hold_q     <= '0;
      idx_q      <= '0;
      batch_q    <= '0;
      mask_q     <= '0;
      interrupt  <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      rd_err     <= 1'b0;
      batch_done <= 1'b0;
      missed     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fire_q     <= fire_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      batch_q    <= batch_d;
      mask_q     <= mask_d;
      interrupt  <= int_d;
      data       <= data_d;
      data_valid <= valid_d;
      rd_err     <= err_d;
      batch_done <= done_d;
      missed     <= missed_d;
    end
  end

  // Beat storage, written one beat per refill cycle
  always_ff @(posedge clk) begin
    if (wr_en) begin
      storage[fill_off] <= fill_beat;
    end
  end

endmodule
